// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: common data bus transmit side.
// Each functional unit pushes completions into its own small FIFO. A round-robin arbiter picks
// one non-empty FIFO per cycle, and the winning entry is registered onto the CDB.
// Optional build macro CDB_BYPASS_EN: an FU whose FIFO is empty may compete with its live input.
// If that FU wins, the input goes straight to the CDB register and is never written to the FIFO.
// Without the macro, only queued entries compete, so a result appears on the CDB two cycles after it is accepted.
module cdb_broadcaster #(
    parameter int NUM_FU  = 4,
    parameter int XLEN    = 32,
    parameter int ROB_LEN = 8,
    parameter int Q_DEPTH = 2,
    localparam int TAG_W  = $clog2(ROB_LEN)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    squash_i,
    input  logic [NUM_FU-1:0]       fu_valid_i,
    input  logic [NUM_FU*TAG_W-1:0] fu_tag_i,
    input  logic [NUM_FU*XLEN-1:0]  fu_value_i,
    input  logic [NUM_FU-1:0]       fu_take_branch_i,
    output logic [NUM_FU-1:0]       fu_ready_o,
    output logic                    cdb_tag_valid_o,
    output logic [TAG_W-1:0]        cdb_tag_o,
    output logic [XLEN-1:0]         cdb_value_o,
    output logic                    cdb_take_branch_o
);

    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(Q_DEPTH);
    localparam logic [RR_W:0]    NUM_FU_W = (RR_W+1)'(NUM_FU);

    // Per-FU FIFO storage; Q_DEPTH is a power of two so pointers wrap naturally
    logic [TAG_W-1:0] mem_tag_q   [NUM_FU][Q_DEPTH];
    logic [XLEN-1:0]  mem_value_q [NUM_FU][Q_DEPTH];
    logic             mem_br_q    [NUM_FU][Q_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q [NUM_FU];
    logic [PTR_W-1:0] wr_ptr_d [NUM_FU];
    logic [PTR_W-1:0] rd_ptr_q [NUM_FU];
    logic [PTR_W-1:0] rd_ptr_d [NUM_FU];
    logic [CNT_W-1:0] count_q  [NUM_FU];
    logic [CNT_W-1:0] count_d  [NUM_FU];

    logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [XLEN-1:0]  cdb_value_q, cdb_value_d;
    logic             cdb_br_q, cdb_br_d;

    logic [NUM_FU-1:0] not_empty;
    logic [NUM_FU-1:0] bypass_cand;
    logic [NUM_FU-1:0] cand;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic              grant_found;
    logic [RR_W-1:0]   grant_idx;
    logic [RR_W:0]     scan;
    logic [RR_W:0]     rr_next;

    // Occupancy flags; ready looks only at the registered count, so a same-cycle pop gives no credit
    always_comb begin
        not_empty  = '0;
        fu_ready_o = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            not_empty[i]  = (count_q[i] != '0);
            fu_ready_o[i] = (count_q[i] != FULL_CNT);
        end
    end

    // Arbitration candidates: queued entries, plus live inputs on empty FIFOs when bypass is built in
    always_comb begin
        bypass_cand = '0;
`ifdef CDB_BYPASS_EN
        bypass_cand = ~not_empty & fu_valid_i;
`endif
        cand = not_empty | bypass_cand;
    end

    // Round-robin search starting at rr_ptr; the first candidate found wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            scan = {1'b0, rr_ptr_q} + (RR_W+1)'(j);
            if (scan >= NUM_FU_W) begin
                scan = scan - NUM_FU_W;
            end
            if (!grant_found && cand[scan[RR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[RR_W-1:0];
            end
        end
    end

    // Push/pop strobes; a bypassed input is consumed directly and never written into its FIFO
    always_comb begin
        push = '0;
        pop  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            pop[i]  = grant_found && (grant_idx == RR_W'(i)) && not_empty[i];
            push[i] = fu_valid_i[i] && fu_ready_o[i]
                      && !(grant_found && (grant_idx == RR_W'(i)) && bypass_cand[i]);
        end
        if (squash_i) begin
            push = '0;
            pop  = '0;
        end
    end

    // FIFO pointer and count next state; squash empties every FIFO
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            count_d[i]  = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            if (squash_i) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end
        end
    end

    // CDB register and round-robin pointer next state; with no winner the payload holds and valid drops
    always_comb begin
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;
        cdb_br_d    = cdb_br_q;
        rr_ptr_d    = rr_ptr_q;
        rr_next     = {1'b0, grant_idx} + (RR_W+1)'(1);
        if (rr_next >= NUM_FU_W) begin
            rr_next = '0;
        end
        if (squash_i) begin
            rr_ptr_d = '0;
        end else if (grant_found) begin
            cdb_valid_d = 1'b1;
            rr_ptr_d    = rr_next[RR_W-1:0];
            if (not_empty[grant_idx]) begin
                cdb_tag_d   = mem_tag_q[grant_idx][rd_ptr_q[grant_idx]];
                cdb_value_d = mem_value_q[grant_idx][rd_ptr_q[grant_idx]];
                cdb_br_d    = mem_br_q[grant_idx][rd_ptr_q[grant_idx]];
            end else begin
                cdb_tag_d   = fu_tag_i[int'(grant_idx)*TAG_W +: TAG_W];
                cdb_value_d = fu_value_i[int'(grant_idx)*XLEN +: XLEN];
                cdb_br_d    = fu_take_branch_i[grant_idx];
            end
        end
    end

    // FIFO data write; contents need no reset because count gates every read
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                mem_tag_q[i][wr_ptr_q[i]]   <= fu_tag_i[i*TAG_W +: TAG_W];
                mem_value_q[i][wr_ptr_q[i]] <= fu_value_i[i*XLEN +: XLEN];
                mem_br_q[i][wr_ptr_q[i]]    <= fu_take_branch_i[i];
            end
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            cdb_br_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            cdb_br_q    <= cdb_br_d;
        end
    end

    assign cdb_tag_valid_o   = cdb_valid_q;
    assign cdb_tag_o         = cdb_tag_q;
    assign cdb_value_o       = cdb_value_q;
    assign cdb_take_branch_o = cdb_br_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed testbench for cdb_broadcaster (4 FUs, 32-bit values, 3-bit tags, FIFO depth 2).
module tb_cdb_broadcaster;

`ifdef CDB_BYPASS_EN
    localparam int LAT     = 1;
    localparam int EXP_LOW = 3;
`else
    localparam int LAT     = 2;
    localparam int EXP_LOW = 2;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         squash;
    logic [3:0]   fu_valid;
    logic [11:0]  fu_tag;
    logic [127:0] fu_value;
    logic [3:0]   fu_br;
    logic [3:0]   fu_ready;
    logic         cdb_tag_valid;
    logic [2:0]   cdb_tag;
    logic [31:0]  cdb_value;
    logic         cdb_take_branch;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_broadcaster #(.NUM_FU(4), .XLEN(32), .ROB_LEN(8), .Q_DEPTH(2)) dut (
        .clock             (clock),
        .reset             (reset),
        .squash_i          (squash),
        .fu_valid_i        (fu_valid),
        .fu_tag_i          (fu_tag),
        .fu_value_i        (fu_value),
        .fu_take_branch_i  (fu_br),
        .fu_ready_o        (fu_ready),
        .cdb_tag_valid_o   (cdb_tag_valid),
        .cdb_tag_o         (cdb_tag),
        .cdb_value_o       (cdb_value),
        .cdb_take_branch_o (cdb_take_branch)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        squash   = 1'b0;
        fu_valid = '0;
        fu_tag   = '0;
        fu_value = '0;
        fu_br    = '0;
    endtask

    task automatic set_fu(input int i, input logic [2:0] tag, input logic [31:0] val, input logic br);
        fu_valid[i]         = 1'b1;
        fu_tag[i*3 +: 3]    = tag;
        fu_value[i*32 +: 32] = val;
        fu_br[i]            = br;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (cdb_tag_valid !== 1'b0 || cdb_tag !== 3'd0 || cdb_value !== 32'd0 || cdb_take_branch !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b tag=%0d val=%h br=%0b, expected all zero",
                     cdb_tag_valid, cdb_tag, cdb_value, cdb_take_branch);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (cdb_tag_valid !== 1'b0 || fu_ready !== 4'b1111) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got valid=%0b ready=%b, expected 0 / 1111",
                         c, cdb_tag_valid, fu_ready);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        set_fu(0, 3'd3, 32'hDEAD_BEEF, 1'b0);
        tick();
        clear_inputs();
        for (int c = 1; c < LAT; c++) begin
            n_tests++;
            if (cdb_tag_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_early: got valid=%0b expected 0", cdb_tag_valid);
            end
            tick();
        end
        n_tests++;
        if (cdb_tag_valid !== 1'b1 || cdb_tag !== 3'd3 || cdb_value !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_bcast: got v=%0b tag=%0d val=%h expected 1/3/deadbeef",
                     cdb_tag_valid, cdb_tag, cdb_value);
        end
        tick();
        n_tests++;
        if (cdb_tag_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: got valid=%0b expected 0", cdb_tag_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) set_fu(i, 3'(i), 32'h1000_0000 + 32'(i), 1'b0);
        tick();
        clear_inputs();
        for (int c = 1; c < LAT; c++) tick();
        for (int j = 0; j < 4; j++) begin
            n_tests++;
            if (cdb_tag_valid !== 1'b1 || cdb_tag !== 3'(j) || cdb_value !== 32'h1000_0000 + 32'(j)) begin
                n_fail++;
                $display("FAIL rr_order slot %0d: got v=%0b tag=%0d val=%h expected tag %0d",
                         j, cdb_tag_valid, cdb_tag, cdb_value, j);
            end
            if (j < 3) tick();
        end
        set_fu(2, 3'd5, 32'h2000_0005, 1'b0);
        set_fu(0, 3'd4, 32'h2000_0004, 1'b0);
        tick();
        clear_inputs();
        for (int c = 1; c < LAT; c++) begin
            n_tests++;
            if (cdb_tag_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_gap: got valid=%0b expected 0", cdb_tag_valid);
            end
            tick();
        end
        n_tests++;
        if (cdb_tag_valid !== 1'b1 || cdb_tag !== 3'd4 || cdb_value !== 32'h2000_0004) begin
            n_fail++;
            $display("FAIL rr_wrap_first: got v=%0b tag=%0d expected tag 4", cdb_tag_valid, cdb_tag);
        end
        tick();
        n_tests++;
        if (cdb_tag_valid !== 1'b1 || cdb_tag !== 3'd5 || cdb_value !== 32'h2000_0005) begin
            n_fail++;
            $display("FAIL rr_wrap_second: got v=%0b tag=%0d expected tag 5", cdb_tag_valid, cdb_tag);
        end
        tick();
        n_tests++;
        if (cdb_tag_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_drained: got valid=%0b expected 0", cdb_tag_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] tags0 [4];
        logic [2:0] tags1 [3];
        int idx0, idx1, got0, got1, n_bc, first_low;
        logic acc0, acc1;
        tags0[0] = 3'd4; tags0[1] = 3'd5; tags0[2] = 3'd6; tags0[3] = 3'd7;
        tags1[0] = 3'd1; tags1[1] = 3'd2; tags1[2] = 3'd3;
        idx0 = 0; idx1 = 0; got0 = 0; got1 = 0; n_bc = 0; first_low = -1;
        do_reset();
        for (int cyc = 0; cyc < 30; cyc++) begin
            clear_inputs();
            if (idx0 < 4) set_fu(0, tags0[idx0], 32'hA000_0000 + 32'(tags0[idx0]), 1'b0);
            if (idx1 < 3) set_fu(1, tags1[idx1], 32'hB000_0000 + 32'(tags1[idx1]), 1'b0);
            if (fu_ready[1] == 1'b0 && first_low < 0) first_low = cyc;
            acc0 = fu_valid[0] && fu_ready[0];
            acc1 = fu_valid[1] && fu_ready[1];
            tick();
            if (acc0) idx0++;
            if (acc1) idx1++;
            if (cdb_tag_valid === 1'b1) begin
                n_bc++;
                n_tests++;
                if (cdb_tag >= 3'd4) begin
                    if (got0 >= 4 || cdb_tag !== tags0[got0 % 4] || cdb_value !== 32'hA000_0000 + 32'(tags0[got0 % 4])) begin
                        n_fail++;
                        $display("FAIL bp_fu0_order #%0d: got tag=%0d val=%h", got0, cdb_tag, cdb_value);
                    end
                    got0++;
                end else begin
                    if (got1 >= 3 || cdb_tag !== tags1[got1 % 3] || cdb_value !== 32'hB000_0000 + 32'(tags1[got1 % 3])) begin
                        n_fail++;
                        $display("FAIL bp_fu1_order #%0d: got tag=%0d val=%h", got1, cdb_tag, cdb_value);
                    end
                    got1++;
                end
            end
        end
        clear_inputs();
        n_tests++;
        if (n_bc != 7 || got0 != 4 || got1 != 3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d broadcasts (fu0 %0d fu1 %0d) expected 7 (4, 3)", n_bc, got0, got1);
        end
        n_tests++;
        if (first_low != EXP_LOW) begin
            n_fail++;
            $display("FAIL bp_ready_low: fu_ready[1] first low in cycle %0d expected %0d", first_low, EXP_LOW);
        end
    endtask

    task automatic test_branch();
        do_reset();
        set_fu(3, 3'd6, 32'h0000_0066, 1'b1);
        tick();
        clear_inputs();
        for (int c = 1; c < LAT; c++) tick();
        n_tests++;
        if (cdb_tag_valid !== 1'b1 || cdb_tag !== 3'd6 || cdb_take_branch !== 1'b1 || cdb_value !== 32'h66) begin
            n_fail++;
            $display("FAIL branch_taken: got v=%0b tag=%0d br=%0b expected 1/6/1",
                     cdb_tag_valid, cdb_tag, cdb_take_branch);
        end
        set_fu(2, 3'd2, 32'h0000_0022, 1'b0);
        tick();
        clear_inputs();
        for (int c = 1; c < LAT; c++) tick();
        n_tests++;
        if (cdb_tag_valid !== 1'b1 || cdb_tag !== 3'd2 || cdb_take_branch !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_not_taken: got v=%0b tag=%0d br=%0b expected 1/2/0",
                     cdb_tag_valid, cdb_tag, cdb_take_branch);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int cyc = 0; cyc < 6 + LAT; cyc++) begin
            clear_inputs();
            if (cyc < 6) set_fu(0, 3'(cyc), 32'hC0DE_0000 + 32'(cyc), 1'b0);
            n_tests++;
            if (cyc >= LAT) begin
                if (cdb_tag_valid !== 1'b1 || cdb_tag !== 3'(cyc - LAT) || cdb_value !== 32'hC0DE_0000 + 32'(cyc - LAT)
                    || fu_ready[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b cycle %0d: got v=%0b tag=%0d val=%h ready0=%0b expected tag %0d",
                             cyc, cdb_tag_valid, cdb_tag, cdb_value, fu_ready[0], cyc - LAT);
                end
            end else begin
                if (cdb_tag_valid !== 1'b0 || fu_ready[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_lead cycle %0d: got v=%0b ready0=%0b expected 0/1",
                             cyc, cdb_tag_valid, fu_ready[0]);
                end
            end
            tick();
        end
        clear_inputs();
        n_tests++;
        if (cdb_tag_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got valid=%0b expected 0", cdb_tag_valid);
        end
    endtask

    task automatic test_squash();
        do_reset();
        for (int i = 0; i < 4; i++) set_fu(i, 3'(i), 32'h3000_0000 + 32'(i), 1'b0);
        tick();
        clear_inputs();
        set_fu(0, 3'd4, 32'h3000_0004, 1'b0);
        set_fu(1, 3'd5, 32'h3000_0005, 1'b0);
        set_fu(2, 3'd6, 32'h3000_0006, 1'b0);
        tick();
        clear_inputs();
        squash = 1'b1;
        set_fu(3, 3'd7, 32'h3000_0007, 1'b0);
        tick();
        clear_inputs();
        n_tests++;
        if (cdb_tag_valid !== 1'b0 || fu_ready !== 4'b1111) begin
            n_fail++;
            $display("FAIL squash_next: got valid=%0b ready=%b expected 0 / 1111", cdb_tag_valid, fu_ready);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            n_tests++;
            if (cdb_tag_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL squash_stale cycle %0d: got valid=%0b tag=%0d expected no broadcast",
                         c, cdb_tag_valid, cdb_tag);
            end
        end
        set_fu(1, 3'd1, 32'h4000_0001, 1'b0);
        set_fu(0, 3'd0, 32'h4000_0000, 1'b0);
        tick();
        clear_inputs();
        for (int c = 1; c < LAT; c++) tick();
        n_tests++;
        if (cdb_tag_valid !== 1'b1 || cdb_tag !== 3'd0) begin
            n_fail++;
            $display("FAIL squash_rr_reset: got v=%0b tag=%0d expected 1/0", cdb_tag_valid, cdb_tag);
        end
        tick();
        n_tests++;
        if (cdb_tag_valid !== 1'b1 || cdb_tag !== 3'd1) begin
            n_fail++;
            $display("FAIL squash_rr_second: got v=%0b tag=%0d expected 1/1", cdb_tag_valid, cdb_tag);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 4; i++) set_fu(i, 3'(i), 32'h5000_0000 + 32'(i), 1'b0);
        tick();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if (cdb_tag_valid !== 1'b0 || fu_ready !== 4'b1111 || cdb_tag !== 3'd0 || cdb_value !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_next: got v=%0b ready=%b tag=%0d val=%h expected 0/1111/0/0",
                     cdb_tag_valid, fu_ready, cdb_tag, cdb_value);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            n_tests++;
            if (cdb_tag_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_stale cycle %0d: got valid=%0b tag=%0d expected 0",
                         c, cdb_tag_valid, cdb_tag);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_branch();
        test_back_to_back();
        test_squash();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
